// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results into an in-order queue that
// drives the register-file write port, and tracks outstanding writes per register.
module wb_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [ADDR_W-1:0]             alu_addr,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_data,
  input  logic                          rsv_valid,
  input  logic [ADDR_W-1:0]             rsv_addr,
  output logic                          rf_write,
  output logic [ADDR_W-1:0]             rf_w_addr,
  output logic [DATA_W-1:0]             rf_d_in,
  output logic [(1<<ADDR_W)-1:0]        pending,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 1 << ADDR_W;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [NREG-1:0]  pending_q, pending_d;

  logic             mem_enq, alu_enq;
  logic [PTR_W-1:0] alu_slot;

  // Ready looks only at registered occupancy so there is no path from the pop.
  always_comb begin
    mem_ready = !reset && (count_q < CNT_W'(DEPTH));
    alu_ready = !reset && ((count_q + CNT_W'(mem_valid)) < CNT_W'(DEPTH));
    mem_enq   = mem_valid && mem_ready && (mem_addr != '0);
    alu_enq   = alu_valid && alu_ready && (alu_addr != '0);
    alu_slot  = tail_q + PTR_W'(mem_enq);

    rf_write  = !reset && (count_q != '0);
    rf_w_addr = addr_q[head_q];
    rf_d_in   = data_q[head_q];

    head_d    = head_q + PTR_W'(rf_write);
    tail_d    = tail_q + PTR_W'(mem_enq) + PTR_W'(alu_enq);
    count_d   = count_q + CNT_W'(mem_enq) + CNT_W'(alu_enq) - CNT_W'(rf_write);

    // Clear on pop first so a same-cycle reservation of that register wins.
    pending_d = pending_q;
    if (rf_write) pending_d[rf_w_addr] = 1'b0;
    if (rsv_valid && (rsv_addr != '0)) pending_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Queue storage needs no reset; occupancy alone qualifies the head.
  always_ff @(posedge clk) begin
    if (mem_enq) begin
      addr_q[tail_q] <= mem_addr;
      data_q[tail_q] <= mem_data;
    end
    if (alu_enq) begin
      addr_q[alu_slot] <= alu_addr;
      data_q[alu_slot] <= alu_data;
    end
  end

  assign pending = pending_q;
  assign count   = count_q;

endmodule
